// File: rtl/counter_sequencer_pkg.sv
// Shared types and defaults for the counter_sequencer interval timer.
package counter_sequencer_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/counter_sequencer_core.sv
// Free-running up-counter core: synchronous clear beats enable, increments modulo 2^WIDTH.
module counter_core
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out = cnt_q;

endmodule

// File: rtl/counter_sequencer.sv
// Interval-timer controller: sequences counter_core through IDLE/RUN/HOLD and
// produces tick (terminal count), done (one-shot completion) and busy.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             periodic_q, periodic_d;
  logic             done_q, done_d;
  logic             clr, en;
  logic             at_term;

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .out   (count)
  );

  assign at_term = (count == period_q);

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;
    clr        = 1'b0;
    en         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d    = RUN;
          period_d   = period;
          periodic_d = periodic;
          clr        = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else if (pause) begin
          state_d = HOLD;
        end else if (at_term) begin
          // Terminal count: reload for periodic, otherwise finish and flag done.
          clr = 1'b1;
          if (!periodic_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          en = 1'b1;
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        clr     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      period_q   <= '0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign tick = (state_q == RUN) & at_term & ~stop & ~pause;
  assign done = done_q;

endmodule
